// File: rtl/estacionamiento_pkg.sv
// Shared types for the parking gate front end: FSM states, A/B beam codes, next-state table.
// Pure declarations; no latency, no flow control.
// Next-state function holds the legal occlusion sequences for entry and exit.
package estacionamiento_pkg;

    typedef enum logic [2:0] {
        IDLE, ENT_A, ENT_AB, ENT_B, SAL_B, SAL_AB, SAL_A, FALLO
    } estado_gate_t;

    localparam logic [1:0] AB_LIBRE = 2'b00;
    localparam logic [1:0] AB_B     = 2'b01;
    localparam logic [1:0] AB_A     = 2'b10;
    localparam logic [1:0] AB_AMBOS = 2'b11;

    function automatic estado_gate_t siguiente_estado(input estado_gate_t e, input logic [1:0] ab);
        estado_gate_t s;
        s = e;
        case (e)
            IDLE:   case (ab) AB_A: s = ENT_A;  AB_B: s = SAL_B;  AB_AMBOS: s = FALLO;  default: s = IDLE;   endcase
            ENT_A:  case (ab) AB_AMBOS: s = ENT_AB; AB_LIBRE: s = IDLE;  AB_B: s = FALLO;  default: s = ENT_A;  endcase
            ENT_AB: case (ab) AB_B: s = ENT_B;  AB_A: s = ENT_A;  AB_LIBRE: s = FALLO;  default: s = ENT_AB; endcase
            ENT_B:  case (ab) AB_LIBRE: s = IDLE; AB_AMBOS: s = ENT_AB; AB_A: s = FALLO;  default: s = ENT_B;  endcase
            SAL_B:  case (ab) AB_AMBOS: s = SAL_AB; AB_LIBRE: s = IDLE;  AB_A: s = FALLO;  default: s = SAL_B;  endcase
            SAL_AB: case (ab) AB_A: s = SAL_A;  AB_B: s = SAL_B;  AB_LIBRE: s = FALLO;  default: s = SAL_AB; endcase
            SAL_A:  case (ab) AB_LIBRE: s = IDLE; AB_AMBOS: s = SAL_AB; AB_B: s = FALLO;  default: s = SAL_A;  endcase
            FALLO:  s = (ab == AB_LIBRE) ? IDLE : FALLO;
            default: s = IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/filtro_sensor.sv
// One beam sensor: 2-FF synchronizer, plus debounce filter when DETECTOR_DEBOUNCE_EN is defined.
// Latency 2 cycles (+DEBOUNCE_CYCLES with filter); no backpressure, raw input sampled every cycle.
// Filter output follows only after DEBOUNCE_CYCLES consecutive samples differing from it.
module filtro_sensor #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor,
    output logic filtrado
);

    logic [1:0] sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 2'b00;
        else       sync <= {sync[0], sensor};
    end

`ifdef DETECTOR_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt;
    logic          salida;

    // Any sample equal to the current output restarts the run of differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            salida <= 1'b0;
        end else if (sync[1] == salida) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt    <= '0;
            salida <= sync[1];
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign filtrado = salida;
`else
    assign filtrado = sync[1];
`endif

endmodule

// File: rtl/detector_sentido_paso.sv
// Gate direction detector: tracks A/B beam sequence, pulses auto_entra/auto_sale/fallo (DETECTOR_DEBOUNCE_EN adds filter).
// Latency: raw edge to pulse 3 clk edges (+DEBOUNCE_CYCLES with filter); no backpressure, pulses are fire-and-forget.
// Stalled sequences abort to FALLO after TIMEOUT_CYCLES; n_fallos saturates.
module detector_sentido_paso
    import estacionamiento_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FALLOS_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sensor_a,
    input  logic                sensor_b,
    output logic                auto_entra,
    output logic                auto_sale,
    output logic                fallo,
    output logic                ocupado,
    output logic [FALLOS_W-1:0] n_fallos
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic          a_s, b_s;
    logic [1:0]    ab;
    estado_gate_t  estado, est_sig;
    logic [TW-1:0] cnt_to;
    logic          en_espera, vencido, entra_fallo;

    filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_a (
        .clk(clk), .reset(reset), .sensor(sensor_a), .filtrado(a_s)
    );
    filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_b (
        .clk(clk), .reset(reset), .sensor(sensor_b), .filtrado(b_s)
    );

    assign ab          = {a_s, b_s};
    assign est_sig     = siguiente_estado(estado, ab);
    assign en_espera   = (estado == IDLE) || (estado == FALLO);
    // Timeout wins over any simultaneous beam transition.
    assign vencido     = !en_espera && (cnt_to == TW'(TIMEOUT_CYCLES - 1));
    assign entra_fallo = vencido || ((est_sig == FALLO) && (estado != FALLO));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado     <= IDLE;
            cnt_to     <= '0;
            auto_entra <= 1'b0;
            auto_sale  <= 1'b0;
            fallo      <= 1'b0;
            n_fallos   <= '0;
        end else begin
            auto_entra <= !vencido && (estado == ENT_B) && (ab == AB_LIBRE);
            auto_sale  <= !vencido && (estado == SAL_A) && (ab == AB_LIBRE);
            fallo      <= entra_fallo;
            if (vencido) begin
                estado <= FALLO;
                cnt_to <= '0;
            end else begin
                estado <= est_sig;
                cnt_to <= ((est_sig != estado) || en_espera) ? '0 : cnt_to + 1'b1;
            end
            if (entra_fallo && (n_fallos != {FALLOS_W{1'b1}}))
                n_fallos <= n_fallos + 1'b1;
        end
    end

    assign ocupado = (estado != IDLE);

endmodule
